// File: rtl/load_store_unit.sv
// MEM-stage load/store unit for an RV32I pipeline: converts LB/LH/LW/LBU/LHU/SB/SH/SW
// into aligned word accesses, splitting boundary-crossing accesses into two beats.
module load_store_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              done,
    output logic              err,
    output logic [XLEN-1:0]   load_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_we,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int unsigned SH_W = 5;

    typedef enum logic {
        IDLE,
        SPLIT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] lat_addr;
    logic [2:0]        lat_f3;
    logic              lat_load;
    logic [XLEN-1:0]   lat_wdata;
    logic [XLEN-1:0]   hold_q, hold_d;

    logic              accept;
    logic              legal;
    logic              crossing;
    logic              latch_en;
    logic              done_d, err_d, ld_en;
    logic [XLEN-1:0]   ld_d;
    logic [1:0]        req_off, lat_off;
    logic [2:0]        rem;
    logic [SH_W-1:0]   sh0, sh1;
    logic [3:0]        we0, we1;

    function automatic logic [3:0] byte_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   byte_mask = 4'b0001;
            2'b01:   byte_mask = 4'b0011;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] byte_size(input logic [1:0] sz);
        case (sz)
            2'b00:   byte_size = 3'd1;
            2'b01:   byte_size = 3'd2;
            default: byte_size = 3'd4;
        endcase
    endfunction

    function automatic logic is_legal(input logic ld, input logic st, input logic [2:0] f3);
        if (ld && !st)
            is_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                       (f3 == 3'b100) || (f3 == 3'b101);
        else if (st && !ld)
            is_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else
            is_legal = 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
        case (f3)
            3'b000:  extend = {{(XLEN-8){d[7]}}, d[7:0]};
            3'b001:  extend = {{(XLEN-16){d[15]}}, d[15:0]};
            3'b100:  extend = {{(XLEN-8){1'b0}}, d[7:0]};
            3'b101:  extend = {{(XLEN-16){1'b0}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    // Lane arithmetic: beat 0 shifts up by the offset, beat 1 shifts down by the remainder
    assign req_off  = req_addr[1:0];
    assign lat_off  = lat_addr[1:0];
    assign rem      = 3'd4 - {1'b0, lat_off};
    assign sh0      = {req_off, 3'b000};
    assign sh1      = {rem[1:0], 3'b000};
    assign we0      = 4'({4'b0000, byte_mask(req_funct3[1:0])} << req_off);
    assign we1      = byte_mask(lat_f3[1:0]) >> rem;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign legal     = is_legal(req_load, req_store, req_funct3);
    assign crossing  = ({1'b0, req_off} + byte_size(req_funct3[1:0])) > 3'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            done      <= 1'b0;
            err       <= 1'b0;
            load_data <= '0;
            lat_addr  <= '0;
            lat_f3    <= '0;
            lat_load  <= 1'b0;
            lat_wdata <= '0;
            hold_q    <= '0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            err     <= err_d;
            hold_q  <= hold_d;
            if (ld_en)
                load_data <= ld_d;
            if (latch_en) begin
                lat_addr  <= req_addr;
                lat_f3    <= req_funct3;
                lat_load  <= req_load;
                lat_wdata <= req_wdata;
            end
        end
    end

    // Next state, beat drive and completion decode
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ld_en     = 1'b0;
        ld_d      = load_data;
        latch_en  = 1'b0;
        hold_d    = hold_q;
        mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = req_wdata << sh0;
        mem_we    = 4'b0000;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!legal) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (crossing) begin
                        state_d  = SPLIT;
                        latch_en = 1'b1;
                        if (req_store)
                            mem_we = we0;
                        else
                            hold_d = mem_rdata >> sh0;
                    end else begin
                        done_d = 1'b1;
                        if (req_store) begin
                            mem_we = we0;
                        end else begin
                            ld_en = 1'b1;
                            ld_d  = extend(req_funct3, mem_rdata >> sh0);
                        end
                    end
                end
            end
            SPLIT: begin
                state_d   = IDLE;
                done_d    = 1'b1;
                mem_addr  = {lat_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
                mem_wdata = lat_wdata >> sh1;
                if (lat_load) begin
                    ld_en = 1'b1;
                    ld_d  = extend(lat_f3, hold_q | (mem_rdata << sh1));
                end else begin
                    mem_we = we1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-lane word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        done, err;
    logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;
    logic        mem_clr;
    logic [31:0] mem [0:1023];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .err(err), .load_data(load_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    // Word memory: combinational read, lane writes at the rising edge
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic to_neg;
        @(negedge clk);
    endtask

    task automatic to_pos;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = v; req_load = ld; req_store = st;
        req_funct3 = f3; req_addr = a; req_wdata = wd;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_clr = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        to_neg;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready act=%b req=0", req_ready); end
        checks++; if (mem_we !== 4'b0000) begin errors++; $display("FAIL rst_we act=%b req=0000", mem_we); end
        checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL rst_done_err act=%b req=00", {done, err}); end
        checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL rst_load_data act=%h req=0", load_data); end
        to_pos;
        mem_clr = 1'b0; rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        to_neg;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready act=%b req=1", req_ready); end
        to_pos;
    endtask

    task automatic test_word;
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        to_neg;
        checks++; if (mem_we !== 4'b1111) begin errors++; $display("FAIL sw_we act=%b req=1111", mem_we); end
        checks++; if (mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL sw_addr act=%h req=00000100", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata act=%h req=deadbeef", mem_wdata); end
        to_pos;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        to_neg;
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL sw_done act=%b req=10", {done, err}); end
        checks++; if (mem_we !== 4'b0000) begin errors++; $display("FAIL lw_we act=%b req=0000", mem_we); end
        to_pos;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        to_neg;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL lw_done act=%b req=1", done); end
        checks++; if (load_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data act=%h req=deadbeef", load_data); end
        to_pos;
    endtask

    task automatic test_byte;
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5);
        to_neg;
        checks++; if (mem_we !== 4'b1000) begin errors++; $display("FAIL sb_we act=%b req=1000", mem_we); end
        checks++; if (mem_wdata[31:24] !== 8'hA5) begin errors++; $display("FAIL sb_lane act=%h req=a5", mem_wdata[31:24]); end
        to_pos;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0);
        to_pos;
        drive(1'b1, 1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0);
        to_neg;
        checks++; if (load_data !== 32'hFFFF_FFA5 || done !== 1'b1) begin errors++; $display("FAIL lb_data act=%h done=%b req=ffffffa5", load_data, done); end
        to_pos;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        to_neg;
        checks++; if (load_data !== 32'h0000_00A5 || done !== 1'b1) begin errors++; $display("FAIL lbu_data act=%h done=%b req=000000a5", load_data, done); end
        to_pos;
    endtask

    task automatic test_split_store;
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0302, 32'h1122_3344);
        to_neg;
        checks++; if (mem_addr !== 32'h0000_0300 || mem_we !== 4'b1100) begin errors++; $display("FAIL ssw_beat0 act=%h/%b req=00000300/1100", mem_addr, mem_we); end
        checks++; if (mem_wdata[31:16] !== 16'h3344) begin errors++; $display("FAIL ssw_wdata0 act=%h req=3344", mem_wdata[31:16]); end
        to_pos;
        // Pipeline presents the next request while the unit is busy; it must be ignored
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0302, 32'h0);
        to_neg;
        checks++; if (req_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ssw_busy ready=%b done=%b req=0/0", req_ready, done); end
        checks++; if (mem_addr !== 32'h0000_0304 || mem_we !== 4'b0011) begin errors++; $display("FAIL ssw_beat1 act=%h/%b req=00000304/0011", mem_addr, mem_we); end
        checks++; if (mem_wdata[15:0] !== 16'h1122) begin errors++; $display("FAIL ssw_wdata1 act=%h req=1122", mem_wdata[15:0]); end
        to_pos;
        to_neg;
        checks++; if (done !== 1'b1 || req_ready !== 1'b1) begin errors++; $display("FAIL ssw_done done=%b ready=%b req=1/1", done, req_ready); end
        checks++; if (mem_we !== 4'b0000) begin errors++; $display("FAIL slw_we0 act=%b req=0000", mem_we); end
        to_pos;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        to_neg;
        checks++; if (done !== 1'b0 || mem_we !== 4'b0000) begin errors++; $display("FAIL slw_beat1 done=%b we=%b req=0/0000", done, mem_we); end
        to_pos;
        to_neg;
        checks++; if (done !== 1'b1 || load_data !== 32'h1122_3344) begin errors++; $display("FAIL slw_data act=%h done=%b req=11223344", load_data, done); end
        to_pos;
    endtask

    task automatic test_split_half;
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0007, 32'h0000_0080);
        to_pos;
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0008, 32'h0000_00FF);
        to_pos;
        drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0007, 32'h0);
        to_neg;
        checks++; if (mem_addr !== 32'h0000_0004) begin errors++; $display("FAIL lh_beat0 act=%h req=00000004", mem_addr); end
        to_pos;
        drive(1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0007, 32'h0);
        to_neg;
        checks++; if (mem_addr !== 32'h0000_0008 || req_ready !== 1'b0) begin errors++; $display("FAIL lh_beat1 act=%h ready=%b req=00000008/0", mem_addr, req_ready); end
        to_pos;
        to_neg;
        checks++; if (load_data !== 32'hFFFF_FF80 || done !== 1'b1) begin errors++; $display("FAIL lh_data act=%h done=%b req=ffffff80", load_data, done); end
        to_pos;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        to_pos;
        to_neg;
        checks++; if (load_data !== 32'h0000_FF80 || done !== 1'b1) begin errors++; $display("FAIL lhu_data act=%h done=%b req=0000ff80", load_data, done); end
        to_pos;
    endtask

    task automatic test_wrap;
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'hFFFF_FFFC, 32'hAABB_CCDD);
        to_pos;
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0000, 32'h5566_7788);
        to_pos;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'hFFFF_FFFD, 32'h0);
        to_neg;
        checks++; if (mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_beat0 act=%h req=fffffffc", mem_addr); end
        to_pos;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        to_neg;
        checks++; if (mem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_beat1 act=%h req=00000000", mem_addr); end
        to_pos;
        to_neg;
        checks++; if (load_data !== 32'h88AA_BBCC || done !== 1'b1) begin errors++; $display("FAIL wrap_data act=%h done=%b req=88aabbcc", load_data, done); end
        to_pos;
    endtask

    task automatic test_illegal;
        drive(1'b1, 1'b0, 1'b1, 3'b011, 32'h0000_0040, 32'h1234_5678);
        to_neg;
        checks++; if (mem_we !== 4'b0000) begin errors++; $display("FAIL ill_we act=%b req=0000", mem_we); end
        to_pos;
        drive(1'b1, 1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h0);
        to_neg;
        checks++; if ({done, err} !== 2'b11) begin errors++; $display("FAIL ill_done_err act=%b req=11", {done, err}); end
        checks++; if (load_data !== 32'h88AA_BBCC) begin errors++; $display("FAIL ill_hold act=%h req=88aabbcc", load_data); end
        checks++; if (mem_we !== 4'b0000) begin errors++; $display("FAIL ill2_we act=%b req=0000", mem_we); end
        to_pos;
        drive(1'b1, 1'b1, 1'b0, 3'b110, 32'h0000_0040, 32'h0);
        to_neg;
        checks++; if ({done, err} !== 2'b11) begin errors++; $display("FAIL ill2_done_err act=%b req=11", {done, err}); end
        to_pos;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        to_neg;
        checks++; if ({done, err} !== 2'b11 || load_data !== 32'h88AA_BBCC) begin errors++; $display("FAIL ill3 act=%b/%h req=11/88aabbcc", {done, err}, load_data); end
        to_pos;
        to_neg;
        checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL ill_quiet act=%b req=00", {done, err}); end
        to_pos;
    endtask

    task automatic test_reset_split;
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0001, 32'hCAFE_F00D);
        to_neg;
        checks++; if (mem_we !== 4'b1110) begin errors++; $display("FAIL rs_beat0 act=%b req=1110", mem_we); end
        to_pos;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        to_neg;
        checks++; if (mem_we !== 4'b0000 || done !== 1'b0) begin errors++; $display("FAIL rs_no_beat1 we=%b done=%b req=0000/0", mem_we, done); end
        to_pos;
        rst = 1'b0;
        to_neg;
        checks++; if (req_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rs_release ready=%b done=%b req=1/0", req_ready, done); end
        to_pos;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0);
        to_pos;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0004, 32'h0);
        to_neg;
        checks++; if (load_data !== 32'hFEF0_0D88) begin errors++; $display("FAIL rs_beat0_kept act=%h req=fef00d88", load_data); end
        to_pos;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        to_neg;
        checks++; if (load_data !== 32'h8000_0000) begin errors++; $display("FAIL rs_beat1_absent act=%h req=80000000", load_data); end
        to_pos;
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte;
        test_split_store;
        test_split_half;
        test_wrap;
        test_illegal;
        test_reset_split;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
